// File: rtl/sobel_wr_ctrl_pkg.sv
// Shared types and constants for the Sobel write-back controller.
//   t_line     : one 512-bit filter beat / host cache line (16 RGBA pixels)
//   t_cl_addr  : cache-line address
//   t_wr_state : controller FSM encoding
package sobel_pkg;

  localparam int SOBEL_LINE_W        = 512;
  localparam int SOBEL_ADDR_W        = 42;
  localparam int SOBEL_BEATS_PER_ROW = 32;
  // The filter's row buffers need two full rows before its output is valid.
  localparam int SOBEL_SKIP_BEATS    = 2 * SOBEL_BEATS_PER_ROW;

  typedef logic [SOBEL_LINE_W-1:0] t_line;
  typedef logic [SOBEL_ADDR_W-1:0] t_cl_addr;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} t_wr_state;

endpackage

// File: rtl/sobel_wr_ctrl_if.sv
// Beat-in / write-out bus of the Sobel write-back controller.
//   in_valid/in_data     : filter output beats
//   in_almost_full       : throttle back to the read side
//   wr_valid/addr/data   : cache-line write requests
//   wr_almost_full       : write channel backpressure
//   wr_rsp_valid         : one write acknowledged
// slave  = controller view, master = environment view.
interface sobel_wr_if #(
  parameter int LINE_W = sobel_pkg::SOBEL_LINE_W,
  parameter int ADDR_W = sobel_pkg::SOBEL_ADDR_W
) ();
  logic              in_valid;
  logic [LINE_W-1:0] in_data;
  logic              in_almost_full;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] wr_data;
  logic              wr_almost_full;
  logic              wr_rsp_valid;

  modport slave (
    input  in_valid, in_data, wr_almost_full, wr_rsp_valid,
    output in_almost_full, wr_valid, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_data, wr_almost_full, wr_rsp_valid,
    input  in_almost_full, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/sobel_wr_ctrl_fifo.sv
// sobel_wr_fifo: synchronous line FIFO.
//   push_i/din_i : write a line (dropped when full unless popping)
//   pop_i        : remove head (ignored when empty)
//   head_o       : current head line
//   count_o      : occupancy, full_o / empty_o flags
// Push and pop in the same cycle are both honoured even when full: the
// freed slot is the one written, so pointers never overrun each other.
module sobel_wr_fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/sobel_wr_ctrl.sv
// sobel_wr_ctrl: write-back stage behind the Sobel filter.
// Drops the row-buffer warm-up beats of each frame, buffers the rest and
// issues sequential cache-line writes from out_base, then reports done
// once every issued write is acknowledged.
//   clk, rst_b          : clock, synchronous active-low reset
//   start               : pulse; latches out_base / num_lines (IDLE/DONE only)
//   out_base, num_lines : first line address, input beats in the frame
//   bus (slave)         : beat input, write request/response channel
//   busy, done, err     : RUN|DRAIN, DONE, sticky overflow/stray-beat flag
// Build option SOBEL_WR_PAD_TAIL_EN: after the buffer drains, append
// min(SKIP_BEATS, num_lines) all-zero lines so the output frame is exactly
// num_lines lines long.
module sobel_wr_ctrl
  import sobel_pkg::*;
#(
  parameter int LINE_W     = SOBEL_LINE_W,
  parameter int ADDR_W     = SOBEL_ADDR_W,
  parameter int CNT_W      = 32,
  parameter int SKIP_BEATS = SOBEL_SKIP_BEATS,
  parameter int FIFO_DEPTH = 64,
  parameter int AF_SLACK   = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [CNT_W-1:0]  num_lines,
  sobel_wr_if.slave         bus,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  t_wr_state         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  nlines_q, nlines_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;
  logic              err_q, err_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LINE_W-1:0] wr_data_q, wr_data_d;
  logic              pad_done;

  logic              push, pop;
  logic [LINE_W-1:0] fifo_head;
  logic [FCW-1:0]    fifo_cnt;
  logic              fifo_full, fifo_empty;

  sobel_wr_fifo #(.W(LINE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push_i  (push),
    .din_i   (bus.in_data),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef SOBEL_WR_PAD_TAIL_EN
  logic [CNT_W-1:0] pad_cnt_q, pad_cnt_d;
  logic [CNT_W-1:0] pad_total;
  assign pad_total = (nlines_q < CNT_W'(SKIP_BEATS)) ? nlines_q : CNT_W'(SKIP_BEATS);
  assign pad_done  = (pad_cnt_q == pad_total);
`else
  assign pad_done  = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    nlines_d   = nlines_q;
    in_cnt_d   = in_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    err_d      = err_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    push       = 1'b0;
    pop        = 1'b0;
`ifdef SOBEL_WR_PAD_TAIL_EN
    pad_cnt_d  = pad_cnt_q;
`endif

    // Write issue: one line per cycle whenever data is buffered and the
    // write channel has room; the request is registered for timing.
    if (!fifo_empty && !bus.wr_almost_full) begin
      pop        = 1'b1;
      wr_valid_d = 1'b1;
      wr_addr_d  = base_q + ADDR_W'(wr_cnt_q);
      wr_data_d  = fifo_head;
      wr_cnt_d   = wr_cnt_q + 1'b1;
    end
`ifdef SOBEL_WR_PAD_TAIL_EN
    // Zero tail only once real data has fully drained, so the zero lines
    // land after the last filtered line in the address sequence.
    else if (state_q == DRAIN && fifo_empty && !pad_done && !bus.wr_almost_full) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = base_q + ADDR_W'(wr_cnt_q);
      wr_data_d  = '0;
      wr_cnt_d   = wr_cnt_q + 1'b1;
      pad_cnt_d  = pad_cnt_q + 1'b1;
    end
`endif

    if (bus.wr_rsp_valid && state_q != IDLE) rsp_cnt_d = rsp_cnt_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          base_d    = out_base;
          nlines_d  = num_lines;
          in_cnt_d  = '0;
          wr_cnt_d  = '0;
          rsp_cnt_d = '0;
          err_d     = 1'b0;
`ifdef SOBEL_WR_PAD_TAIL_EN
          pad_cnt_d = '0;
`endif
          state_d   = (num_lines == '0) ? DONE : RUN;
        end
        if (bus.in_valid) err_d = 1'b1;
      end
      RUN: begin
        if (bus.in_valid) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q >= CNT_W'(SKIP_BEATS)) begin
            push = 1'b1;
            // FIFO refuses the beat; flag it rather than corrupt the ring.
            if (fifo_full && !pop) err_d = 1'b1;
          end
          if (in_cnt_q == nlines_q - 1'b1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.in_valid) err_d = 1'b1;
        if (fifo_empty && !wr_valid_q && pad_done && rsp_cnt_q == wr_cnt_q)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      base_q     <= '0;
      nlines_q   <= '0;
      in_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rsp_cnt_q  <= '0;
      err_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef SOBEL_WR_PAD_TAIL_EN
      pad_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      nlines_q   <= nlines_d;
      in_cnt_q   <= in_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      err_q      <= err_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef SOBEL_WR_PAD_TAIL_EN
      pad_cnt_q  <= pad_cnt_d;
`endif
    end
  end

  // Reserve AF_SLACK entries for beats already in flight upstream.
  assign bus.in_almost_full = (fifo_cnt >= FCW'(FIFO_DEPTH - AF_SLACK));
  assign bus.wr_valid       = wr_valid_q;
  assign bus.wr_addr        = wr_addr_q;
  assign bus.wr_data        = wr_data_q;
  assign busy               = (state_q == RUN) || (state_q == DRAIN);
  assign done               = (state_q == DONE);
  assign err                = err_q;
endmodule
